// File: rtl/mips32_pkg.sv
// rtl/mips32_pkg.sv - shared constants for the MIPS32 core memory subsystem
//
// Purpose: port index encoding used by the arbiter's read-owner register,
//          plus instruction encodings shared by the core and its bench.
// Ports:   none (package).

package mips32_pkg;

  // Requester index; PORT_NONE marks "no read in flight".
  typedef enum logic [1:0] {
    PORT_LD   = 2'd0,
    PORT_DM   = 2'd1,
    PORT_IF   = 2'd2,
    PORT_NONE = 2'd3
  } port_e;

  localparam logic [31:0] NOP_INSTR = 32'h0c631800;
  localparam logic [31:0] HLT_INSTR = 32'hfc000000;

  // One-hot {ld, dm, if} view of a port index.
  function automatic logic [2:0] port_onehot(input port_e p);
    case (p)
      PORT_LD: port_onehot = 3'b100;
      PORT_DM: port_onehot = 3'b010;
      PORT_IF: port_onehot = 3'b001;
      default: port_onehot = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mips32_word_ram.sv
// rtl/mips32_word_ram.sv - single-port synchronous word RAM, 1-cycle read
//
// Purpose: unified program/data store behind mips32_mem_arbiter.
// Ports:
//   clk            in   clock
//   en / we        in   access enable / write enable
//   addr           in   word address (ADDR_W)
//   wdata          in   write data (DATA_W)
//   rdata          out  read data, valid the cycle after en=1 with we=0

module mips32_word_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // A single port means a read and a write never share a cycle, so no
  // read-during-write bypass is needed.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mips32_mem_arbiter.sv
// rtl/mips32_mem_arbiter.sv - fixed-priority single-port RAM arbiter with fetch starvation guard
//
// Purpose: shares one synchronous RAM between the loader (ld), the MEM-stage
//          data port (dm) and the IF-stage fetch (if). Priority ld > dm > if,
//          except fetch jumps ahead of dm once it has been denied STARVE_LIM
//          consecutive cycles. Read data returns one cycle after grant.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   halted                            core halted; masks fetch requests
//   ld_req/ld_we/ld_addr/ld_wdata     loader request
//   ld_gnt/ld_rvalid                  loader grant / read valid
//   dm_req/dm_we/dm_addr/dm_wdata     data-port request
//   dm_gnt/dm_rvalid                  data-port grant / read valid
//   if_req/if_addr                    fetch request (read only)
//   if_gnt/if_rvalid                  fetch grant / instruction valid
//   rdata                             read data broadcast to all requesters
//   mem_en/mem_we/mem_addr/mem_wdata  RAM command
//   mem_rdata                         RAM read data

module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halted,

  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,

  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,

  output logic [DATA_W-1:0] rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0]  LIM   = CNT_W'(STARVE_LIM);

  port_e            gnt_sel;
  port_e            owner_d,      owner_q;
  logic [CNT_W-1:0] starve_cnt_d, starve_cnt_q;
  logic             if_ok;
  logic             starve_hit;

  // Fetch only competes while the core is running.
  assign if_ok      = if_req && !halted;
  assign starve_hit = if_ok && (starve_cnt_q == LIM);

  always_comb begin
    gnt_sel = PORT_NONE;
    if (!rst) begin
      if (ld_req) begin
        gnt_sel = PORT_LD;
      end else if (starve_hit) begin
        gnt_sel = PORT_IF;
      end else if (dm_req) begin
        gnt_sel = PORT_DM;
      end else if (if_ok) begin
        gnt_sel = PORT_IF;
      end
    end
  end

  assign ld_gnt = (gnt_sel == PORT_LD);
  assign dm_gnt = (gnt_sel == PORT_DM);
  assign if_gnt = (gnt_sel == PORT_IF);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (gnt_sel)
      PORT_LD: begin
        mem_en    = 1'b1;
        mem_we    = ld_we;
        mem_addr  = ld_addr;
        mem_wdata = ld_wdata;
      end
      PORT_DM: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      PORT_IF: begin
        mem_en    = 1'b1;
        mem_addr  = if_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    // Only reads need a return path; writes finish in the grant cycle.
    owner_d = (mem_en && !mem_we) ? gnt_sel : PORT_NONE;

    starve_cnt_d = starve_cnt_q;
    if (!if_ok || if_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != LIM) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= PORT_NONE;
      starve_cnt_q <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign ld_rvalid = (owner_q == PORT_LD);
  assign dm_rvalid = (owner_q == PORT_DM);
  assign if_rvalid = (owner_q == PORT_IF);
  assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb/tb_mips32_mem_arbiter.sv - scoreboard bench for mips32_mem_arbiter

module tb_mips32_mem_arbiter;
  import mips32_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              halted;
  logic              ld_req, ld_we, ld_gnt, ld_rvalid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  mips32_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst), .halted(halted),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mips32_word_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ram (
    .clk(clk), .en(mem_en), .we(mem_we), .addr(mem_addr),
    .wdata(mem_wdata), .rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  pv;
    logic [31:0] data;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] ref_mem [1024];
  logic [31:0] prog [8];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One arbitration cycle: retire the read issued last cycle, check this
  // cycle's grant, then record expected read data / model writes.
  task automatic step(input string tag, input logic [2:0] exp_gnt);
    sb_t        e;
    logic [2:0] obs;
    @(negedge clk);
    obs = {ld_rvalid, dm_rvalid, if_rvalid};
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rv"}, 64'(obs), 64'(e.pv));
      if (obs == e.pv) chk({tag, "_rdata"}, 64'(rdata), 64'(e.data));
    end else begin
      chk({tag, "_norv"}, 64'(obs), 64'd0);
    end
    chk({tag, "_gnt"}, 64'({ld_gnt, dm_gnt, if_gnt}), 64'(exp_gnt));
    chk({tag, "_en"}, 64'(mem_en), 64'(|exp_gnt));
    case (exp_gnt)
      3'b100: if (ld_we) ref_mem[ld_addr] = ld_wdata;
              else sb.push_back('{3'b100, ref_mem[ld_addr]});
      3'b010: if (dm_we) ref_mem[dm_addr] = dm_wdata;
              else sb.push_back('{3'b010, ref_mem[dm_addr]});
      3'b001: sb.push_back('{3'b001, ref_mem[if_addr]});
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    if_req = 0; if_addr = '0;
  endtask

  initial begin
    prog = '{32'h28010078, NOP_INSTR, 32'h20020005, 32'h00431020,
             32'hac010079, 32'h8c030079, NOP_INSTR, HLT_INSTR};
    idle_inputs();
    halted = 0;
    rst = 1;
    dm_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'({ld_gnt, dm_gnt, if_gnt}), 64'd0);
    chk("rst_rv", 64'({ld_rvalid, dm_rvalid, if_rvalid}), 64'd0);
    chk("rst_mem", 64'({mem_en, mem_we}), 64'd0);
    chk("rst_starve", 64'(dut.starve_cnt_q), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();

    // Loader writes, including the program image.
    ld_req = 1; ld_we = 1;
    ld_addr = 10'd0;   ld_wdata = prog[0];      step("ld_w0", 3'b100);
    ld_addr = 10'd120; ld_wdata = 32'd85;       step("ld_w120", 3'b100);
    for (int i = 1; i < 8; i++) begin
      ld_addr = 10'(i); ld_wdata = prog[i];     step("ld_wprog", 3'b100);
    end
    ld_we = 0; ld_addr = 10'd120;               step("ld_r120", 3'b100);
    idle_inputs();                              step("idle0", 3'b000);

    // Fetch sweep, one instruction per cycle.
    if_req = 1;
    for (int i = 0; i < 8; i++) begin
      if_addr = 10'(i);                         step("if_sweep", 3'b001);
    end
    idle_inputs();                              step("idle1", 3'b000);

    // dm beats if; if follows next cycle.
    dm_req = 1; dm_addr = 10'd120; if_req = 1; if_addr = 10'd2;
    step("dm_over_if", 3'b010);
    dm_req = 0;                                 step("if_after_dm", 3'b001);
    idle_inputs();                              step("idle2", 3'b000);

    // Starvation guard: SW 130 -> 121 held with fetch held.
    dm_req = 1; dm_we = 1; dm_addr = 10'd121; dm_wdata = 32'd130;
    if_req = 1; if_addr = 10'd3;
    for (int i = 0; i < 4; i++) begin
      step("starve_deny", 3'b010);
      chk("starve_cnt", 64'(dut.starve_cnt_q), 64'(i + 1));
    end
    step("starve_gnt", 3'b001);
    chk("starve_clr", 64'(dut.starve_cnt_q), 64'd0);
    if_req = 0;                                 step("sw_only", 3'b010);
    dm_we = 0;                                  step("dm_r121", 3'b010);
    idle_inputs();                              step("idle3", 3'b000);

    // All three at once: ld wins, fetch eligible so count rises.
    ld_req = 1; ld_addr = 10'd0; dm_req = 1; dm_addr = 10'd121;
    if_req = 1; if_addr = 10'd7;
    step("all3", 3'b100);
    chk("all3_starve", 64'(dut.starve_cnt_q), 64'd1);
    ld_req = 0;                                 step("dm_if", 3'b010);
    chk("dm_if_starve", 64'(dut.starve_cnt_q), 64'd2);
    dm_req = 0;                                 step("if_last", 3'b001);
    chk("if_last_starve", 64'(dut.starve_cnt_q), 64'd0);
    idle_inputs();                              step("idle4", 3'b000);

    // Halted: fetch masked, others served.
    halted = 1; if_req = 1; if_addr = 10'd4;
    for (int i = 0; i < 10; i++) begin
      dm_req = (i % 2) == 1; dm_addr = 10'd120;
      ld_req = (i == 4); ld_addr = 10'd5;
      step("halt", ld_req ? 3'b100 : (dm_req ? 3'b010 : 3'b000));
      chk("halt_starve", 64'(dut.starve_cnt_q), 64'd0);
    end
    halted = 0;
    idle_inputs();                              step("idle5", 3'b000);

    // Reset at the end of a read grant cycle drops the read.
    dm_req = 1; dm_addr = 10'd120;
    @(negedge clk);
    chk("rstmid_norv", 64'({ld_rvalid, dm_rvalid, if_rvalid}), 64'd0);
    chk("rstmid_gnt", 64'(dm_gnt), 64'd1);
    rst = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_rv", 64'({ld_rvalid, dm_rvalid, if_rvalid}), 64'd0);
    chk("rstmid_gnt0", 64'({ld_gnt, dm_gnt, if_gnt}), 64'd0);
    chk("rstmid_mem", 64'({mem_en, mem_we}), 64'd0);
    chk("rstmid_starve", 64'(dut.starve_cnt_q), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    step("post_rst_dm", 3'b010);
    idle_inputs();                              step("idle6", 3'b000);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips32_mem_arbiter.md
# mips32_mem_arbiter

Single-port memory arbiter for the pipelined MIPS32 core. The core's unified word memory holds both program and data. This block shares one synchronous single-port RAM between three requesters: the bench/boot loader, the MEM-stage data port, and the IF-stage instruction fetch. It applies fixed priority with a starvation guard for fetch and returns read data one cycle after grant.

## Interface
Parameters:
- ADDR_W, 10, word-address width (1024 × 32-bit words)
- DATA_W, 32, data width
- STARVE_LIM, 4, consecutive denied fetch cycles before fetch is forced ahead of the data port

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- halted  in  1  core HALTED flag; while 1, fetch requests are ignored
- ld_req / ld_we  in  1 / 1  loader request / write enable
- ld_addr / ld_wdata  in  ADDR_W / DATA_W  loader address / write data
- ld_gnt / ld_rvalid  out  1 / 1  loader grant / read data valid
- dm_req / dm_we  in  1 / 1  data-port request / write enable (LW=0, SW=1)
- dm_addr / dm_wdata  in  ADDR_W / DATA_W  data address / store data
- dm_gnt / dm_rvalid  out  1 / 1  data-port grant / read data valid
- if_req / if_addr  in  1 / ADDR_W  fetch request (read-only) / PC word address
- if_gnt / if_rvalid  out  1 / 1  fetch grant / instruction valid
- rdata  out  DATA_W  read data, broadcast to all requesters; meaningful only with a *_rvalid
- mem_en / mem_we  out  1 / 1  RAM enable / write enable
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  RAM address / write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en=1 with mem_we=0

## Operation
- At most one grant per cycle. Grant is combinational from the current requests and starvation state.
- Priority: ld over dm over if. Exception: when starve_cnt == STARVE_LIM and if_req=1 and halted=0, fetch beats dm. Fetch never beats ld.
- Granted requester drives mem_* in the same cycle: mem_en=1, mem_we=requester we (fetch always 0), plus addr and wdata. With no grant, mem_en=0 and mem_we=0.
- Writes complete in the grant cycle and produce no rvalid.
- Reads: owner is registered at grant. In the next cycle, exactly that requester's rvalid=1 and rdata=mem_rdata.
- A requester holds req, addr and we stable until it sees gnt. Dropping req before gnt is legal and cancels the request.
- starve_cnt (width clog2(STARVE_LIM+1)) behaves as follows:
  - +1 when if_req=1, halted=0 and if_gnt=0
  - saturates at STARVE_LIM
  - cleared to 0 on if_gnt, if_req=0, or halted=1
- halted=1: if_gnt held 0. Loader and data port are unaffected.

## Timing
- Reset values: all *_gnt=0, all *_rvalid=0, mem_en=0, mem_we=0, starve_cnt=0, read owner=none. mem_addr, mem_wdata and rdata are don't-care but must be driven (no X on control).
- While rst=1, all grants are forced to 0.
- Read latency: grant in cycle T, rvalid pulses for exactly 1 cycle in T+1. Back-to-back grants give one read result per cycle.
- Write latency: 0. RAM is updated at the rising edge ending cycle T. A read of the same address granted in T+1 returns the new data in T+2.
- Reset mid-read: if rst=1 at the edge ending grant cycle T, no rvalid appears in T+1 and the read is dropped.
- Simultaneous ld+dm+if: ld granted. dm and if wait. starve_cnt increments only if fetch was eligible.
- Continuous dm_req with if_req: fetch is granted no later than STARVE_LIM+1 cycles after its request, unless ld is active.

## Structure
- Shared package mips32_pkg holds:
  - port index constants PORT_NONE=2'd3, PORT_LD=0, PORT_DM=1, PORT_IF=2 (for the owner register)
  - NOP encoding 32'h0c631800 and HLT 32'hfc000000, used by the bench and the core
- The arbiter is a single flat module.
- One natural sub-module for verification and integration: mips32_word_ram (single-port synchronous RAM, 1-cycle read, write-first disabled: a read in the same cycle as a write to that address is not possible with a single port).

## Test plan
- Loader writes 32'h28010078 to address 0 and 85 to address 120 → ld_gnt in the same cycle each; no rvalid; a later ld read of address 120 gives ld_rvalid with rdata=85 one cycle after grant.
- if_req alone with if_addr=0 → if_gnt in the same cycle, if_rvalid next cycle, rdata=32'h28010078; PC sweep 0..7 back-to-back returns the program with one instruction per cycle.
- dm read of address 120 and if read of address 2 in the same cycle → dm_gnt; dm_rvalid next cycle with rdata=85; if_gnt one cycle later and if_rvalid the cycle after that.
- dm_req held continuously (SW of 130 to address 121) with if_req held and STARVE_LIM=4 → fetch denied 4 cycles then granted on the 5th; starve_cnt returns to 0; the Mem[121] read afterwards gives 130.
- halted=1 with if_req=1 for 10 cycles → if_gnt stays 0, starve_cnt stays 0, dm/ld still served.
- Read granted in cycle T and rst=1 at the end of T → no rvalid in T+1; all outputs at reset values; normal arbitration resumes the cycle after rst falls.
